// File: rtl/lru_array_rmw_pkg.sv
// Shared types and constants for the per-set LRU rank array.
package lru_array_rmw_pkg;

  localparam int LRU_WAYS_W = 3;
  localparam int LRU_IDX_W  = 6;

  // One way's rank (0 = MRU) and one set's vector of ranks.
  typedef logic [LRU_WAYS_W-1:0] rankT;
  typedef rankT [2**LRU_WAYS_W-1:0] rankVecT;

  // Rank carried by the least recently used way.
  localparam rankT LRU_RANK = rankT'(2**LRU_WAYS_W - 1);

  // Controller states: INIT sweeps the array, RUN serves requests.
  typedef enum logic {INIT, RUN} stateT;

endpackage

// File: rtl/lru_array_rmw_single.sv
// Next-rank computation for a single way of a set.
module lru_single #(
  parameter int WIDTH = 3
) (
  input  logic [WIDTH-1:0] curLRU,
  input  logic [WIDTH-1:0] hitLRU,
  input  logic [WIDTH-1:0] init,
  input  logic             en,
  output logic [WIDTH-1:0] newLRU
);

  // The touched way takes init; younger ways age by one; older ways keep their rank.
  always_comb begin
    newLRU = curLRU;
    if (en) begin
      if (curLRU == hitLRU) begin
        newLRU = init;
      end else if (curLRU < hitLRU) begin
        newLRU = curLRU + WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/lru_array_rmw.sv
// Per-set true-LRU rank array with a two-stage read-modify-write pipeline.
// Handshake: a request is taken on any rising edge where req_en and
// req_ready are both high; req_ready never depends on req_en.
module lru_array_rmw
  import lru_array_rmw_pkg::*;
#(
  parameter int WAYS_W = LRU_WAYS_W,
  parameter int IDX_W  = LRU_IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_en,
  output logic              req_ready,
  input  logic [IDX_W-1:0]  req_idx,
  input  logic              req_alloc,
  input  logic [WAYS_W-1:0] req_way,
  output logic              vic_valid,
  output logic [WAYS_W-1:0] vic_way,
  output logic              busy
);

  localparam int NWAYS = 1 << WAYS_W;
  localparam int NSETS = 1 << IDX_W;
  localparam int VEC_W = NWAYS * WAYS_W;
  localparam logic [WAYS_W-1:0] LRU_R = '1;

  // Way w of a set lives at bits [w*WAYS_W +: WAYS_W] of the set's word.
  logic [VEC_W-1:0]  rankMem [NSETS];

  stateT             state;
  logic [IDX_W-1:0]  sweepCnt;
  logic              accept;
  logic              fwdHit;
  logic [VEC_W-1:0]  readVec;
  logic              bValid;
  logic [IDX_W-1:0]  bIdx;
  logic              bAlloc;
  logic [WAYS_W-1:0] bWay;
  logic [VEC_W-1:0]  bRanks;
  logic              bWrite;
  logic [WAYS_W-1:0] vicSel;
  logic [WAYS_W-1:0] touched;
  logic [WAYS_W-1:0] hitRank;
  logic [VEC_W-1:0]  newVec;

  // Identity ranking written by the sweep: way k holds rank k.
  function automatic logic [VEC_W-1:0] initVec();
    logic [VEC_W-1:0] v;
    v = '0;
    for (int k = 0; k < NWAYS; k++) begin
      v[k*WAYS_W +: WAYS_W] = WAYS_W'(k);
    end
    return v;
  endfunction

  assign accept    = (state == RUN) && req_en && !flush;
  assign req_ready = (state == RUN) && !flush;
  assign busy      = (state == INIT);
  assign bWrite    = bValid && !flush;
  assign vic_valid = bWrite;
  assign vic_way   = vicSel;

  // Stage A read; a same-set update sitting in stage B is forwarded so no stall is needed.
  always_comb begin
    fwdHit  = bValid && (bIdx == req_idx);
    readVec = fwdHit ? newVec : rankMem[req_idx];
  end

  // Stage B: locate the LRU way and pick the way being touched.
  always_comb begin
    vicSel = '0;
    for (int w = 0; w < NWAYS; w++) begin
      if (bRanks[w*WAYS_W +: WAYS_W] == LRU_R) begin
        vicSel = WAYS_W'(w);
      end
    end
    touched = bAlloc ? vicSel : bWay;
    hitRank = bRanks[int'(touched)*WAYS_W +: WAYS_W];
  end

  for (genvar g = 0; g < NWAYS; g++) begin : g_way
    lru_single #(.WIDTH(WAYS_W)) u_single (
      .curLRU (bRanks[g*WAYS_W +: WAYS_W]),
      .hitLRU (hitRank),
      .init   ('0),
      .en     (bValid),
      .newLRU (newVec[g*WAYS_W +: WAYS_W])
    );
  end

  // Controller FSM and pipeline registers; flush restarts the sweep and kills stage B.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= INIT;
      sweepCnt <= '0;
      bValid   <= 1'b0;
      bIdx     <= '0;
      bAlloc   <= 1'b0;
      bWay     <= '0;
      bRanks   <= '0;
    end else if (flush) begin
      state    <= INIT;
      sweepCnt <= '0;
      bValid   <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          bValid   <= 1'b0;
          sweepCnt <= sweepCnt + IDX_W'(1);
          if (sweepCnt == IDX_W'(NSETS - 1)) begin
            state <= RUN;
          end
        end
        RUN: begin
          bValid <= accept;
          if (accept) begin
            bIdx   <= req_idx;
            bAlloc <= req_alloc;
            bWay   <= req_way;
            bRanks <= readVec;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

  // Rank storage: sweep writes the identity ranking, stage B writes back updates.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (state == INIT) begin
        rankMem[sweepCnt] <= initVec();
      end else if (bValid) begin
        rankMem[bIdx] <= newVec;
      end
    end
  end

endmodule

// File: tb/tb_lru_array_rmw.sv
// Self-checking bench for lru_array_rmw: reference rank model plus victim scoreboard.
module tb_lru_array_rmw;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       req_en;
  logic       req_ready;
  logic [5:0] req_idx;
  logic       req_alloc;
  logic [2:0] req_way;
  logic       vic_valid;
  logic [2:0] vic_way;
  logic       busy;

  int         modelRank [64][8];
  logic [2:0] exp_q [$];
  int         passCnt = 0;
  int         checkCnt = 0;

  lru_array_rmw #(.WAYS_W(3), .IDX_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .req_en    (req_en),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .req_alloc (req_alloc),
    .req_way   (req_way),
    .vic_valid (vic_valid),
    .vic_way   (vic_way),
    .busy      (busy)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCnt++;
    if (obs === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Reference model
  function automatic void model_reset();
    for (int s = 0; s < 64; s++)
      for (int w = 0; w < 8; w++) modelRank[s][w] = w;
  endfunction

  function automatic logic [23:0] model_word(input int idx);
    logic [23:0] v;
    v = '0;
    for (int w = 0; w < 8; w++) v[w*3 +: 3] = 3'(modelRank[idx][w]);
    return v;
  endfunction

  function automatic logic [2:0] model_access(input int idx, input logic alloc, input int way);
    int vic, t, old;
    vic = 0;
    for (int w = 0; w < 8; w++) if (modelRank[idx][w] == 7) vic = w;
    t = alloc ? vic : way;
    old = modelRank[idx][t];
    for (int w = 0; w < 8; w++) begin
      if (w == t) modelRank[idx][w] = 0;
      else if (modelRank[idx][w] < old) modelRank[idx][w] = modelRank[idx][w] + 1;
    end
    return 3'(vic);
  endfunction

  function automatic logic is_perm(input logic [23:0] v);
    logic [7:0] seen;
    seen = '0;
    for (int w = 0; w < 8; w++) seen[v[w*3 +: 3]] = 1'b1;
    return seen == 8'hff;
  endfunction

  // Driver tasks (all called at posedge + 1)
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input int idx, input logic alloc, input int way);
    req_en    = 1'b1;
    req_idx   = 6'(idx);
    req_alloc = alloc;
    req_way   = 3'(way);
    check_val("req_ready", 32'(req_ready), 32'd1);
    exp_q.push_back(model_access(idx, alloc, way));
    cycle();
    req_en = 1'b0;
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      cycle();
      n++;
    end
    check_val(tag, n, 64);
    check_val({tag, "_busy_low"}, 32'(busy), 32'd0);
  endtask

  task automatic check_set(input string tag, input int s);
    check_val(tag, 32'(dut.rankMem[s]), 32'(model_word(s)));
  endtask

  task automatic check_all(input string tag);
    for (int s = 0; s < 64; s++) check_set(tag, s);
  endtask

  // Scoreboard: every victim result is popped against the queued expectation
  always @(negedge clk) begin
    if (vic_valid) begin
      if (exp_q.size() == 0) check_val("vic_unexpected", 32'd1, 32'd0);
      else check_val("vic_way", 32'(vic_way), 32'(exp_q.pop_front()));
    end
  end

  // Main sequence
  initial begin
    rst = 1'b1; flush = 1'b0; req_en = 1'b0;
    req_idx = '0; req_alloc = 1'b0; req_way = '0;
    model_reset();
    #1;
    check_val("rst_busy", 32'(busy), 32'd1);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_vic_valid", 32'(vic_valid), 32'd0);
    check_val("rst_vic_way", 32'(vic_way), 32'd0);
    repeat (3) cycle();
    rst = 1'b0;
    wait_init("init_cycles");
    check_set("set5_identity", 5);
    check_all("init_all");

    // Alloc on a fresh set evicts way 7
    do_req(3, 1'b1, 0);
    cycle();
    check_set("set3_after_alloc", 3);

    // Hit then alloc on the same set back to back (forwarding path)
    do_req(3, 1'b0, 2);
    do_req(3, 1'b1, 0);
    cycle();
    check_set("set3_fwd", 3);

    // Eight consecutive allocs walk the victim down 7..0
    for (int i = 0; i < 8; i++) do_req(9, 1'b1, 0);
    cycle();
    check_set("set9_allocs", 9);
    check_val("set9_perm", 32'(is_perm(dut.rankMem[9])), 32'd1);

    // Random traffic over a few sets, with idle gaps
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) == 0) cycle();
      else do_req($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end
    cycle();
    cycle();
    check_all("random_all");
    for (int s = 0; s < 4; s++) check_val("random_perm", 32'(is_perm(dut.rankMem[s])), 32'd1);

    // Flush with a request in stage B and another offered in the same cycle
    req_en = 1'b1; req_idx = 6'd20; req_alloc = 1'b1; req_way = '0;
    check_val("pre_flush_ready", 32'(req_ready), 32'd1);
    cycle();
    flush = 1'b1; req_idx = 6'd20;
    #1;
    check_val("flush_ready", 32'(req_ready), 32'd0);
    check_val("flush_vic_valid", 32'(vic_valid), 32'd0);
    cycle();
    flush = 1'b0; req_en = 1'b0;
    check_val("post_flush_vic_valid", 32'(vic_valid), 32'd0);
    model_reset();
    wait_init("flush_cycles");
    check_all("flush_all");

    // Reset in the middle of a sweep restarts from set 0
    do_req(40, 1'b1, 0);
    do_req(50, 1'b0, 4);
    cycle();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    repeat (30) cycle();
    check_val("mid_sweep_count", 32'(dut.sweepCnt), 32'd30);
    rst = 1'b1;
    #1;
    check_val("mid_rst_busy", 32'(busy), 32'd1);
    cycle();
    rst = 1'b0;
    model_reset();
    wait_init("rst_mid_cycles");
    check_all("rst_mid_all");
    do_req(40, 1'b1, 0);
    cycle();
    check_set("set40_after_restart", 40);

    repeat (2) cycle();
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule
